// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, receiver states and token lookup.
// Used by both the receive path and the transmit-side encoder.
package tmds_pkg;

    localparam int unsigned SYMBOL_BITS = 10;

    localparam logic [SYMBOL_BITS-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYMBOL_BITS-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYMBOL_BITS-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYMBOL_BITS-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH,
        LOCKED
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } token_match_t;

    function automatic token_match_t token_lookup(input logic [SYMBOL_BITS-1:0] sym);
        token_match_t m;
        m = '0;
        case (sym)
            CTRL_TOKEN_00: m = '{hit: 1'b1, code: 2'b00};
            CTRL_TOKEN_01: m = '{hit: 1'b1, code: 2'b01};
            CTRL_TOKEN_10: m = '{hit: 1'b1, code: 2'b10};
            CTRL_TOKEN_11: m = '{hit: 1'b1, code: 2'b11};
            default:       m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tmds_channel_receiver_if.sv
// Serial input and decoded-symbol outputs of one TMDS receive lane.
interface tmds_channel_receiver_if;
    logic       tmds_serial;
    logic       locked;
    logic       sym_valid;
    logic [9:0] raw_symbol;
    logic [7:0] data;
    logic       de;
    logic [1:0] ctrl;

    modport master (
        output tmds_serial,
        input  locked, sym_valid, raw_symbol, data, de, ctrl
    );

    modport slave (
        input  tmds_serial,
        output locked, sym_valid, raw_symbol, data, de, ctrl
    );
endinterface

// File: rtl/tmds_symbol_decoder.sv
// Combinational TMDS symbol decoder: control token lookup, else inverse
// of the transition-minimising XOR/XNOR chain.
module tmds_symbol_decoder
    import tmds_pkg::*;
(
    input  logic [SYMBOL_BITS-1:0] symbol,
    output logic [7:0]             data,
    output logic                   de,
    output logic [1:0]             ctrl,
    output logic                   is_token
);
    token_match_t tm;
    logic [7:0]   q;

    always_comb begin
        tm       = token_lookup(symbol);
        q        = symbol[9] ? ~symbol[7:0] : symbol[7:0];
        data     = '0;
        de       = 1'b0;
        ctrl     = '0;
        is_token = tm.hit;
        if (tm.hit) begin
            ctrl = tm.code;
        end else begin
            de      = 1'b1;
            data[0] = q[0];
            for (int unsigned i = 1; i < 8; i++)
                data[i] = symbol[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end
endmodule

// File: rtl/tmds_channel_receiver.sv
// One TMDS receive lane: bit-rate deserialiser, token-based word alignment
// with lock/loss tracking, and registered symbol decode.
module tmds_channel_receiver
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_TOKENS  = 4,
    parameter int unsigned LOSS_SYMBOLS = 2048
) (
    input  logic                   clk,
    input  logic                   reset,
    tmds_channel_receiver_if.slave rx
);
    localparam int unsigned TW       = $clog2(LOCK_TOKENS + 1);
    localparam logic [TW-1:0] LOCK_CNT = TW'(LOCK_TOKENS);
    localparam logic [12:0]   LOSS_LIM = 13'(LOSS_SYMBOLS);

    rx_state_t               state, state_nxt;
    logic [SYMBOL_BITS-1:0]  sr, sr_nxt;
    logic [3:0]              phase, phase_nxt;
    logic [TW-1:0]           token_cnt, token_cnt_nxt, token_inc;
    logic [11:0]             loss_cnt, loss_cnt_nxt;
    logic [12:0]             loss_inc;
    logic                    boundary, emit;

    logic [7:0] dec_data;
    logic       dec_de, dec_is_token;
    logic [1:0] dec_ctrl;

    // Decode the word as it will stand after this edge's shift, so the
    // symbol whose last bit arrives now is presented on the next cycle.
    assign sr_nxt = {rx.tmds_serial, sr[SYMBOL_BITS-1:1]};

    tmds_symbol_decoder u_dec (
        .symbol   (sr_nxt),
        .data     (dec_data),
        .de       (dec_de),
        .ctrl     (dec_ctrl),
        .is_token (dec_is_token)
    );

    always_comb begin
        boundary      = (phase == 4'd9);
        token_inc     = token_cnt + TW'(1);
        loss_inc      = {1'b0, loss_cnt} + 13'd1;
        state_nxt     = state;
        token_cnt_nxt = token_cnt;
        loss_cnt_nxt  = loss_cnt;
        phase_nxt     = boundary ? 4'd0 : phase + 4'd1;
        emit          = 1'b0;
        case (state)
            SEARCH: begin
                // First token may sit at any phase and re-anchors; later ones must be aligned.
                if ((token_cnt == '0 || boundary) && dec_is_token) begin
                    if (token_cnt == '0)
                        phase_nxt = 4'd0;
                    token_cnt_nxt = token_inc;
                    if (token_inc == LOCK_CNT) begin
                        state_nxt    = LOCKED;
                        loss_cnt_nxt = '0;
                    end
                end else if (token_cnt != '0 && boundary) begin
                    token_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (dec_is_token) begin
                        loss_cnt_nxt = '0;
                        emit         = 1'b1;
                    end else if (loss_inc == LOSS_LIM) begin
                        state_nxt     = SEARCH;
                        token_cnt_nxt = '0;
                    end else begin
                        loss_cnt_nxt = loss_inc[11:0];
                        emit         = 1'b1;
                    end
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SEARCH;
            sr            <= '0;
            phase         <= '0;
            token_cnt     <= '0;
            loss_cnt      <= '0;
            rx.locked     <= 1'b0;
            rx.sym_valid  <= 1'b0;
            rx.raw_symbol <= '0;
            rx.data       <= '0;
            rx.de         <= 1'b0;
            rx.ctrl       <= '0;
        end else begin
            state        <= state_nxt;
            sr           <= sr_nxt;
            phase        <= phase_nxt;
            token_cnt    <= token_cnt_nxt;
            loss_cnt     <= loss_cnt_nxt;
            rx.locked    <= (state == LOCKED);
            rx.sym_valid <= emit;
            if (emit) begin
                rx.raw_symbol <= sr_nxt;
                rx.data       <= dec_data;
                rx.de         <= dec_de;
                rx.ctrl       <= dec_ctrl;
            end
        end
    end
endmodule

// File: tb/tb_tmds_channel_receiver.sv
// Directed bench for tmds_channel_receiver: lock, decode, lock loss,
// alignment break and asynchronous reset.
module tb_tmds_channel_receiver;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   pulses;
    int   pulse_sum;
    logic lk_first;

    localparam logic [9:0] TOK0 = 10'h354;
    localparam logic [9:0] TOK1 = 10'h0AB;
    localparam logic [9:0] TOK2 = 10'h154;
    localparam logic [9:0] TOK3 = 10'h2AB;

    tmds_channel_receiver_if rx_if ();

    tmds_channel_receiver #(
        .LOCK_TOKENS  (4),
        .LOSS_SYMBOLS (2048)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_if.tmds_serial = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [9:0] s);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            send_bit(s[i]);
            if (i == 0) lk_first = rx_if.locked;
            if (rx_if.sym_valid === 1'b1) pulses++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(rx_if.locked), 0);
        chk({tag, "_valid"},  32'(rx_if.sym_valid), 0);
        chk({tag, "_raw"},    32'(rx_if.raw_symbol), 0);
        chk({tag, "_data"},   32'(rx_if.data), 0);
        chk({tag, "_de"},     32'(rx_if.de), 0);
        chk({tag, "_ctrl"},   32'(rx_if.ctrl), 0);
    endtask

    initial begin
        // 1: reset held with random serial input
        reset = 1'b1;
        rx_if.tmds_serial = 1'b0;
        repeat (4) begin
            rx_if.tmds_serial = 1'($urandom);
            @(posedge clk);
        end
        #1;
        chk_all_zero("in_reset");
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        chk("pre_lock_locked", 32'(rx_if.locked), 0);

        // 2: four tokens lock, fifth is decoded
        send_sym(TOK0);
        send_sym(TOK0);
        send_sym(TOK0);
        chk("tok3_locked", 32'(rx_if.locked), 0);
        send_sym(TOK0);
        chk("tok4_locked_not_yet", 32'(rx_if.locked), 0);
        chk("tok4_no_pulse", 32'(pulses), 0);
        send_sym(TOK0);
        chk("tok5_locked_first_bit", 32'(lk_first), 1);
        chk("tok5_pulses", 32'(pulses), 1);
        chk("tok5_valid", 32'(rx_if.sym_valid), 1);
        chk("tok5_de", 32'(rx_if.de), 0);
        chk("tok5_ctrl", 32'(rx_if.ctrl), 0);
        chk("tok5_data", 32'(rx_if.data), 0);
        chk("tok5_raw", 32'(rx_if.raw_symbol), 32'h354);
        send_bit(1'b0);
        chk("valid_one_cycle", 32'(rx_if.sym_valid), 0);
        for (int i = 1; i < 10; i++) send_bit(TOK0[i]);

        // 3: data and control decode while locked
        send_sym(10'h100);
        chk("d100_de", 32'(rx_if.de), 1);
        chk("d100_data", 32'(rx_if.data), 32'h00);
        chk("d100_raw", 32'(rx_if.raw_symbol), 32'h100);
        send_sym(10'h2FF);
        chk("d2ff_pulses", 32'(pulses), 1);
        chk("d2ff_de", 32'(rx_if.de), 1);
        chk("d2ff_data", 32'(rx_if.data), 32'hFE);
        chk("d2ff_ctrl", 32'(rx_if.ctrl), 0);
        send_sym(10'h0F0);
        chk("d0f0_data", 32'(rx_if.data), 32'hEE);
        send_sym(10'h155);
        chk("d155_data", 32'(rx_if.data), 32'hFF);
        send_sym(TOK3);
        chk("tok11_ctrl", 32'(rx_if.ctrl), 3);
        chk("tok11_de", 32'(rx_if.de), 0);
        chk("tok11_data", 32'(rx_if.data), 0);
        send_sym(TOK1);
        chk("tok01_ctrl", 32'(rx_if.ctrl), 1);
        send_sym(TOK2);
        chk("tok10_ctrl", 32'(rx_if.ctrl), 2);
        chk("tok10_raw", 32'(rx_if.raw_symbol), 32'h154);

        // 5: 2048 data symbols without a token drop lock
        pulse_sum = 0;
        for (int n = 0; n < 2048; n++) begin
            send_sym(10'h100);
            pulse_sum += pulses;
        end
        chk("loss_pulse_total", 32'(pulse_sum), 2047);
        chk("loss_last_no_pulse", 32'(pulses), 0);
        chk("loss_locked_at_boundary", 32'(rx_if.locked), 1);

        // 4: token, token, break, then four fresh tokens required
        send_sym(TOK0);
        chk("loss_locked_falls", 32'(lk_first), 0);
        chk("search_no_pulse", 32'(pulses), 0);
        chk("search_raw_held", 32'(rx_if.raw_symbol), 32'h100);
        chk("search_de_held", 32'(rx_if.de), 1);
        send_sym(TOK0);
        send_sym(10'h100);
        send_sym(TOK0);
        send_sym(TOK0);
        send_sym(TOK0);
        chk("break_3fresh_locked", 32'(rx_if.locked), 0);
        send_sym(TOK0);
        chk("break_4fresh_locked_not_yet", 32'(rx_if.locked), 0);
        send_sym(TOK0);
        chk("break_relock", 32'(lk_first), 1);
        chk("break_relock_pulse", 32'(pulses), 1);

        // 6: asynchronous reset mid-symbol while locked
        send_sym(10'h2FF);
        chk("pre_rst_data", 32'(rx_if.data), 32'hFE);
        for (int i = 0; i < 5; i++) send_bit(TOK0[i]);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #3 reset = 1'b0;
        send_sym(TOK0);
        send_sym(TOK0);
        send_sym(TOK0);
        send_sym(TOK0);
        chk("rst_4tok_locked_not_yet", 32'(rx_if.locked), 0);
        send_sym(TOK0);
        chk("rst_relock", 32'(rx_if.locked), 1);
        chk("rst_relock_ctrl_pulse", 32'(pulses), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tmds_channel_receiver.md
Name: tmds_channel_receiver

Overview:
- Receive end of one HDMI TMDS lane; mirrors the serializer plus encoder pair on the transmit side.
- Takes the serial bit stream at bit rate on clk.
- Recovers the 10-bit symbol boundary by hunting for control tokens, then decodes each symbol to 8-bit pixel data or the 2-bit control code.
- Used in loopback verification of the transmit path and as the building block of a future 3-lane sink.

Parameters:
LOCK_TOKENS, 4, consecutive boundary-aligned control tokens required to declare lock
LOSS_SYMBOLS, 2048, consecutive aligned symbols without a control token before lock is dropped (12-bit counter)

Ports:
clk  in  1  bit-rate clock; one serial bit sampled per rising edge
reset  in  1  asynchronous, active-high reset
tmds_serial  in  1  serial TMDS bit, LSB of each symbol first
locked  out  1  word alignment achieved
sym_valid  out  1  one-cycle pulse per decoded symbol, only while locked
raw_symbol  out  10  aligned undecoded symbol (bit 0 = first received)
data  out  8  decoded pixel byte (valid when de=1)
de  out  1  1 = data symbol, 0 = control token
ctrl  out  2  control code {c1,c0} (valid when de=0)

Behaviour:
- Reset (async): all outputs 0; shift register sr=0; phase=0; token_cnt=0; loss_cnt=0; state SEARCH. sr=0 matches no token.
- Shift register:
  - sr shifts right each edge; the new bit enters sr[9].
  - After 10 edges, sr[0] holds the oldest bit.
  - phase counts 0..9. A boundary is an edge at which phase==9; phase then wraps to 0.
- Tokens, sr[9:0] value: 1101010100 -> ctrl 00; 0010101011 -> 01; 0101010100 -> 10; 1010101011 -> 11.
- State SEARCH:
  - If token_cnt==0 and sr matches any token at any phase: re-anchor (phase:=0), token_cnt:=1.
  - If token_cnt>0, only boundary edges count:
    - Match: token_cnt++.
    - No match: token_cnt:=0 and no re-anchor on that edge.
  - Matches off-boundary while token_cnt>0 are ignored.
  - When the increment makes token_cnt==LOCK_TOKENS: state:=LOCKED, loss_cnt:=0.
  - locked is registered and rises one cycle later.
  - sym_valid stays 0 and data outputs hold their values while in SEARCH.
- State LOCKED: at each boundary the symbol is decoded.
  - Token match: loss_cnt:=0.
  - No match: loss_cnt++.
  - If loss_cnt would reach LOSS_SYMBOLS: state:=SEARCH, token_cnt:=0. locked falls and no sym_valid is issued for that symbol.
  - Off-boundary token matches are ignored; phase is never re-anchored while LOCKED.
- Decode (registered; outputs update one cycle after the boundary edge, together with the sym_valid pulse):
  - Token: de=0, ctrl=code, data=0.
  - Otherwise de=1, ctrl=0, and:
    - q = sr[9] ? ~sr[7:0] : sr[7:0].
    - data[0] = q[0].
    - For i=1..7: data[i] = sr[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
  - Non-token symbols are never rejected; no disparity checking.
- raw_symbol is updated with sr on every sym_valid pulse.
- Latency: the last bit of a symbol is sampled at edge N; sym_valid, data, de, ctrl and raw_symbol are valid in the cycle after edge N.
- Reset mid-operation returns all state to the reset values immediately, independent of clk.

Decomposition:
- Package tmds_pkg:
  - Four CTRL_TOKEN constants.
  - SYMBOL_BITS=10.
  - Receiver state enum {SEARCH, LOCKED}.
  - Token-to-code lookup function, shared with the transmit-side encoder.
- Sub-module tmds_symbol_decoder: purely combinational, 10-bit symbol in; data, de, ctrl, is_token out. Instantiated once and registered by the parent.

Test Plan:
1. Hold reset, drive random bits, release reset -> all outputs 0, locked=0 until alignment.
2. Send 3 random bits, then 4x token 1101010100 LSB-first -> locked=1 one cycle after the 4th token's last bit; the next token gives sym_valid with de=0, ctrl=00, raw_symbol=0x354.
3. Once locked, send symbol 0x100, then 0x2FF -> sym_valid with de=1, data=0x00, then de=1, data=0xFE.
4. In SEARCH send token, token, data 0x100, then tokens -> locked only after 4 fresh aligned tokens following the break; never earlier.
5. Once locked, send 2048 consecutive 0x100 symbols -> 2047 sym_valid pulses; locked falls one cycle after the 2048th boundary. Sending tokens again relocks after 4.
6. Assert reset asynchronously mid-symbol while locked -> locked, sym_valid, data, de, ctrl and raw_symbol go to 0 before the next clk edge; relock requires 4 tokens.
